// File: rtl/video_pkg.sv
// Shared video definitions: scheduler state encodings, source identifiers,
// colour constants and a saturating counter helper.
package video_pkg;

  typedef enum logic [1:0] {
    ST_PATTERN = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_STREAM  = 2'd2
  } state_e;

  localparam logic SRC_PATTERN = 1'b0;
  localparam logic SRC_STREAM  = 1'b1;

  localparam logic [23:0] COLOR_BLACK = 24'h000000;
  localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COLOR_RED   = 24'hFF0000;
  localparam logic [23:0] COLOR_GREEN = 24'h00FF00;
  localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;
  localparam logic [23:0] FILL_COLOR  = COLOR_BLACK;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/video_position_counter.sv
// Pixel/line position tracker advanced by the sink's ready strobe; flags the
// first pixel of a frame and the consuming strobe of the last pixel.
module video_position_counter #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          frame_start_o,
  output logic          frame_end_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last_s, y_last_s;

  assign x_last_s = (x_q == XW'(H_ACTIVE - 1));
  assign y_last_s = (y_q == YW'(V_ACTIVE - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv_i) begin
      if (x_last_s) begin
        x_d = '0;
        y_d = y_last_s ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = (x_q == '0) && (y_q == '0);
  assign frame_end_o   = adv_i & x_last_s & y_last_s;

endmodule

// File: rtl/video_source_scheduler.sv
// Selects pattern generator or processed stream for the video sink, switching
// only on frame boundaries and realigning to the stream's start-of-frame.
module video_source_scheduler #(
  parameter int          H_ACTIVE   = 800,
  parameter int          V_ACTIVE   = 600,
  parameter logic [23:0] FILL_COLOR = video_pkg::FILL_COLOR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        VideoReady,
  input  logic        SelRequest,
  input  logic        SelTarget,
  input  logic [23:0] PatternVideo,
  output logic        PatternReady,
  input  logic [23:0] StreamVideo,
  input  logic        StreamValid,
  input  logic        StreamSof,
  output logic        StreamReady,
  output logic [23:0] video,
  output logic        ActiveSrc,
  output logic        FrameStart,
  output logic        Underflow,
  output logic        Desync,
  output logic [15:0] UnderflowCount
);

  import video_pkg::*;

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  state_e        state_q;
  logic          pending_q, target_q;
  logic          active_src_q, underflow_q, desync_q;
  logic [15:0]   uf_count_q, uf_count_d;
  logic [XW-1:0] x_s;
  logic [YW-1:0] y_s;
  logic          frame_start_s, frame_end_s;
  logic          dest_s, take_req_s, desync_s, starved_s;

  video_position_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_pos (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .adv_i        (VideoReady),
    .x_o          (x_s),
    .y_o          (y_s),
    .frame_start_o(frame_start_s),
    .frame_end_o  (frame_end_s)
  );

  // ST_ALIGN already heads for the stream, so it shares the stream destination.
  assign dest_s     = (state_q == ST_PATTERN) ? SRC_PATTERN : SRC_STREAM;
  // A fresh request only updates the latch; the latched one acts a cycle later.
  assign take_req_s = pending_q & ~SelRequest;
  assign desync_s   = StreamValid & StreamSof & ((x_s != '0) | (y_s != '0));
  assign starved_s  = VideoReady & ~StreamValid;
  assign uf_count_d = sat_inc16(uf_count_q);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_PATTERN;
      pending_q    <= 1'b0;
      target_q     <= SRC_PATTERN;
      active_src_q <= SRC_PATTERN;
      underflow_q  <= 1'b0;
      desync_q     <= 1'b0;
      uf_count_q   <= 16'd0;
    end else begin
      underflow_q <= 1'b0;
      desync_q    <= 1'b0;
      if (SelRequest) begin
        pending_q <= (SelTarget != dest_s);
        target_q  <= SelTarget;
      end
      case (state_q)
        ST_PATTERN: begin
          if (take_req_s && (target_q == SRC_STREAM)) begin
            state_q   <= ST_ALIGN;
            pending_q <= 1'b0;
          end
        end
        ST_ALIGN: begin
          if (take_req_s && (target_q == SRC_PATTERN)) begin
            state_q   <= ST_PATTERN;
            pending_q <= 1'b0;
          end else if (StreamValid && StreamSof && frame_end_s) begin
            state_q      <= ST_STREAM;
            active_src_q <= SRC_STREAM;
          end
        end
        ST_STREAM: begin
          if (starved_s) begin
            underflow_q <= 1'b1;
            uf_count_q  <= uf_count_d;
          end
          if (desync_s) begin
            desync_q     <= 1'b1;
            state_q      <= ST_ALIGN;
            active_src_q <= SRC_PATTERN;
          end else if (take_req_s && (target_q == SRC_PATTERN) && frame_end_s) begin
            state_q      <= ST_PATTERN;
            pending_q    <= 1'b0;
            active_src_q <= SRC_PATTERN;
          end
        end
        default: begin
          state_q      <= ST_PATTERN;
          pending_q    <= 1'b0;
          active_src_q <= SRC_PATTERN;
        end
      endcase
    end
  end

  always_comb begin
    video       = PatternVideo;
    StreamReady = 1'b0;
    case (state_q)
      ST_PATTERN: begin
        video       = PatternVideo;
        StreamReady = 1'b0;
      end
      ST_ALIGN: begin
        video       = PatternVideo;
        StreamReady = StreamValid & ~StreamSof;
      end
      ST_STREAM: begin
        video       = StreamValid ? StreamVideo : FILL_COLOR;
        StreamReady = VideoReady;
      end
      default: begin
        video       = PatternVideo;
        StreamReady = 1'b0;
      end
    endcase
  end

  assign PatternReady   = VideoReady;
  assign ActiveSrc      = active_src_q;
  assign FrameStart     = frame_start_s;
  assign Underflow      = underflow_q;
  assign Desync         = desync_q;
  assign UnderflowCount = uf_count_q;

endmodule

// File: tb/tb_video_source_scheduler.sv
// Self-checking bench: directed scenarios plus a random soak, each cycle
// compared against a behavioural model of the scheduler rules.
module tb_video_source_scheduler;

  localparam int          H    = 24;
  localparam int          V    = 6;
  localparam int          N    = H * V;
  localparam logic [23:0] FILL = 24'h5A5A5A;
  localparam int M_PAT = 0, M_ALN = 1, M_STR = 2;

  logic        Clock = 1'b0;
  logic        Reset, VideoReady, SelRequest, SelTarget;
  logic        PatternReady, StreamValid, StreamSof, StreamReady;
  logic        ActiveSrc, FrameStart, Underflow, Desync;
  logic [23:0] PatternVideo, StreamVideo, video;
  logic [15:0] UnderflowCount;

  video_source_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .FILL_COLOR(FILL)) dut (
    .Clock(Clock), .Reset(Reset), .VideoReady(VideoReady),
    .SelRequest(SelRequest), .SelTarget(SelTarget),
    .PatternVideo(PatternVideo), .PatternReady(PatternReady),
    .StreamVideo(StreamVideo), .StreamValid(StreamValid), .StreamSof(StreamSof),
    .StreamReady(StreamReady), .video(video), .ActiveSrc(ActiveSrc),
    .FrameStart(FrameStart), .Underflow(Underflow), .Desync(Desync),
    .UnderflowCount(UnderflowCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed { logic sof; logic [23:0] data; } spix_t;
  spix_t sq[$];

  int n_cmp = 0, n_mis = 0, n_pops = 0;
  int m_mode, m_pos, m_cnt;
  bit m_pend, m_tgt, m_uf, m_ds;
  bit vr, req, tgt, gap, force_sof;
  logic [23:0] obs_video;
  bit obs_uf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    spix_t p;
    for (int i = 0; i < N; i++) begin
      p.sof  = (i == 0);
      p.data = 24'($urandom());
      sq.push_back(p);
    end
  endtask

  task automatic model_reset();
    m_mode = M_PAT; m_pos = 0; m_cnt = 0;
    m_pend = 1'b0; m_tgt = 1'b0; m_uf = 1'b0; m_ds = 1'b0;
  endtask

  task automatic cycle();
    spix_t hd;
    bit sv, sofe, fs, fe, dest, take, npend, ntgt, nuf, nds, esr;
    int nmode;
    logic [23:0] pat, evid;
    hd = '0;
    if (sq.size() > 0) hd = sq[0];
    sv   = (sq.size() > 0) && !gap;
    sofe = sv && (hd.sof || force_sof);
    pat  = 24'($urandom());
    VideoReady = vr; SelRequest = req; SelTarget = tgt; PatternVideo = pat;
    StreamValid = sv; StreamSof = sofe; StreamVideo = hd.data;
    fs   = (m_pos == 0);
    fe   = vr && (m_pos == N - 1);
    evid = (m_mode == M_STR) ? (sv ? hd.data : FILL) : pat;
    esr  = (m_mode == M_PAT) ? 1'b0 : (m_mode == M_ALN) ? (sv && !sofe) : vr;
    @(negedge Clock);
    obs_video = video;
    obs_uf    = Underflow;
    chk("video", video, evid);
    chk("pattern_ready", PatternReady, vr);
    chk("stream_ready", StreamReady, esr);
    chk("active_src", ActiveSrc, m_mode == M_STR);
    chk("frame_start", FrameStart, fs);
    chk("underflow", Underflow, m_uf);
    chk("desync", Desync, m_ds);
    chk("uf_count", UnderflowCount, m_cnt);
    dest = (m_mode != M_PAT);
    take = m_pend && !req;
    nmode = m_mode; npend = m_pend; ntgt = m_tgt; nuf = 1'b0; nds = 1'b0;
    if (m_mode == M_PAT) begin
      if (take && m_tgt) begin nmode = M_ALN; npend = 1'b0; end
    end else if (m_mode == M_ALN) begin
      if (take && !m_tgt) begin nmode = M_PAT; npend = 1'b0; end
      else if (sofe && fe) nmode = M_STR;
    end else begin
      nuf = vr && !sv;
      if (sofe && !fs) begin nds = 1'b1; nmode = M_ALN; end
      else if (take && !m_tgt && fe) begin nmode = M_PAT; npend = 1'b0; end
    end
    if (req) begin npend = (tgt != dest); ntgt = tgt; end
    @(posedge Clock);
    #1;
    m_mode = nmode; m_pend = npend; m_tgt = ntgt; m_uf = nuf; m_ds = nds;
    if (nuf && m_cnt < 65535) m_cnt++;
    if (vr) m_pos = (m_pos + 1) % N;
    if (esr && sv) begin sq.delete(0); n_pops++; end
    else if (gap && vr && sq.size() > 0) sq.delete(0);
    while (sq.size() < 2 * N) push_frame();
    req = 1'b0; force_sof = 1'b0;
  endtask

  initial begin
    spix_t p;
    int k, p0, fills, ufs;
    logic [31:0] x0, x3;
    logic [23:0] exp_first;
    vr = 1'b1; req = 1'b0; tgt = 1'b0; gap = 1'b0; force_sof = 1'b0;
    Reset = 1'b1; VideoReady = 1'b0; SelRequest = 1'b0; SelTarget = 1'b0;
    PatternVideo = 24'h0; StreamVideo = 24'h0; StreamValid = 1'b0; StreamSof = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p.sof = 1'b0; p.data = 24'($urandom()); sq.push_back(p);
    end
    while (sq.size() < 2 * N) push_frame();
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_active_src", ActiveSrc, 1'b0);
    chk("reset_underflow", Underflow, 1'b0);
    chk("reset_desync", Desync, 1'b0);
    chk("reset_uf_count", UnderflowCount, 16'd0);
    chk("reset_frame_start", FrameStart, 1'b1);
    Reset = 1'b0;

    // 1: pattern for a whole frame
    repeat (N) cycle();
    chk("t1_wrap_frame_start", FrameStart, 1'b1);

    // 2: switch to stream, flushing 5 stray pixels
    for (int i = 0; i < N && m_pos != 50; i++) cycle();
    p0 = n_pops;
    req = 1'b1; tgt = 1'b1; cycle();
    k = 0;
    while (k < 2 * N && ActiveSrc !== 1'b1) begin cycle(); k++; end
    chk("t2_reached_stream", ActiveSrc, 1'b1);
    chk("t2_flushed", n_pops - p0, 5);
    chk("t2_switch_at_origin", FrameStart, 1'b1);
    exp_first = sq[0].data;
    cycle();
    chk("t2_first_pixel", obs_video, exp_first);

    // 3: three missing stream pixels
    repeat (10) cycle();
    x0 = 32'(dut.x_s);
    fills = 0; ufs = 0;
    gap = 1'b1;
    repeat (3) begin cycle(); fills += (obs_video == FILL) ? 1 : 0; ufs += obs_uf ? 1 : 0; end
    gap = 1'b0;
    x3 = 32'(dut.x_s);
    cycle(); ufs += obs_uf ? 1 : 0;
    chk("t3_fill_count", fills, 3);
    chk("t3_pulses", ufs, 3);
    chk("t3_uf_count", UnderflowCount, 16'd3);
    chk("t3_x_advance", x3 - x0, 3);

    // 4: SOF injected at x=17, y=4
    for (int i = 0; i < N && m_pos != 17 + 4 * H; i++) cycle();
    force_sof = 1'b1; cycle();
    sq.delete(0);
    chk("t4_desync_pulse", Desync, 1'b1);
    chk("t4_left_stream", ActiveSrc, 1'b0);
    chk("t4_pattern_shown", video, PatternVideo);
    k = 0;
    while (k < 2 * N && ActiveSrc !== 1'b1) begin cycle(); k++; end
    chk("t4_realign_delay", k, N - (17 + 4 * H) - 1);
    chk("t4_realign_origin", FrameStart, 1'b1);

    // 5: return to pattern at frame end, then cancelled request
    for (int i = 0; i < N && m_pos != 40; i++) cycle();
    req = 1'b1; tgt = 1'b0; cycle();
    k = 0;
    while (k < 2 * N && ActiveSrc !== 1'b0) begin cycle(); k++; end
    chk("t5_return_delay", k, N - 41);
    chk("t5_return_origin", FrameStart, 1'b1);
    repeat (3) cycle();
    req = 1'b1; tgt = 1'b1; cycle();
    req = 1'b1; tgt = 1'b0; cycle();
    repeat (3) cycle();
    chk("t5_pending_clear", dut.pending_q, 1'b0);
    chk("t5_still_pattern", ActiveSrc, 1'b0);

    // 6: asynchronous reset while streaming
    req = 1'b1; tgt = 1'b1; cycle();
    k = 0;
    while (k < 3 * N && ActiveSrc !== 1'b1) begin cycle(); k++; end
    chk("t6_reached_stream", ActiveSrc, 1'b1);
    repeat (5) cycle();
    gap = 1'b1; cycle(); gap = 1'b0; cycle();
    gap = 1'b1; cycle(); gap = 1'b0; repeat (2) cycle();
    chk("t6_uf_count_pre", UnderflowCount, 16'd5);
    #3 Reset = 1'b1;
    #1;
    chk("t6_active_src", ActiveSrc, 1'b0);
    chk("t6_underflow", Underflow, 1'b0);
    chk("t6_desync", Desync, 1'b0);
    chk("t6_uf_count", UnderflowCount, 16'd0);
    chk("t6_frame_start", FrameStart, 1'b1);
    chk("t6_stream_ready", StreamReady, 1'b0);
    chk("t6_video", video, PatternVideo);
    model_reset();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    // random soak
    for (int i = 0; i < 4000; i++) begin
      vr = (($urandom() % 4) != 0);
      if (($urandom() % 120) == 0) begin req = 1'b1; tgt = 1'($urandom() % 2); end
      gap = (($urandom() % 40) == 0);
      force_sof = (($urandom() % 500) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/video_source_scheduler.md
Name: video_source_scheduler

Overview:
- Chooses which source drives the 24-bit video output to the display sink. Source 0 is the internal colour pattern generator; source 1 is the processed pixel stream from the SIFT datapath.
- Tracks pixel and line position from the sink's VideoReady strobe.
- Changes source only at frame boundaries, aligning to the stream's start-of-frame so the displayed frame is never torn.
- Sits between the pattern generator, the stream output FIFO and the video sink.

Parameters:
H_ACTIVE, 800, active pixels per line
V_ACTIVE, 600, active lines per frame
FILL_COLOR, 24'h000000, pixel emitted on stream underflow

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
VideoReady  in  1  sink consumes `video` this cycle
SelRequest  in  1  one-cycle pulse: request a switch to SelTarget
SelTarget  in  1  0 = pattern, 1 = stream
PatternVideo  in  24  pattern generator pixel
PatternReady  out  1  advance the pattern generator
StreamVideo  in  24  stream pixel
StreamValid  in  1  stream pixel available
StreamSof  in  1  qualifies StreamVideo as first pixel of a frame
StreamReady  out  1  pop the stream pixel
video  out  24  pixel to the sink
ActiveSrc  out  1  source currently on `video`
FrameStart  out  1  high while the pixel at x=0, y=0 is presented
Underflow  out  1  registered one-cycle pulse: a stream pixel was missing
Desync  out  1  registered one-cycle pulse: stream SOF lost
UnderflowCount  out  16  saturating underflow count

Behaviour:
- Reset (async, active-high) sets:
  - state ST_PATTERN, x = 0, y = 0, pending = 0;
  - Underflow = 0, Desync = 0, UnderflowCount = 0, ActiveSrc = 0.
- Position counters:
  - x and y are registers advanced only when VideoReady = 1.
  - x wraps at H_ACTIVE-1 to 0 and then increments y; y wraps at V_ACTIVE-1 to 0.
  - FrameEnd = VideoReady & (x == H_ACTIVE-1) & (y == V_ACTIVE-1).
  - FrameStart = (x == 0 && y == 0), combinational.
- PatternReady = VideoReady in every state, so the pattern generator's phase never slips.
- video is a combinational mux, zero latency; it is PatternVideo except in ST_STREAM.
- Request latch:
  - A SelRequest sets pending = 1 and target = SelTarget; a later request overwrites target.
  - A request equal to the current destination clears pending.
- States:
  - ST_PATTERN:
    - ActiveSrc = 0, StreamReady = 0.
    - On pending with target = 1: clear pending and go to ST_ALIGN.
  - ST_ALIGN:
    - ActiveSrc = 0; the stream is flushed: StreamReady = StreamValid & ~StreamSof, so non-SOF pixels are discarded.
    - A SOF pixel at the head is held (StreamReady = 0) until FrameEnd, then the state goes to ST_STREAM.
    - A pending request with target = 0 returns to ST_PATTERN immediately.
  - ST_STREAM:
    - ActiveSrc = 1 and StreamReady = VideoReady.
    - video = StreamVideo if StreamValid, else FILL_COLOR.
    - If VideoReady & ~StreamValid: the pixel still counts (x advances), Underflow pulses the next cycle, and UnderflowCount increments, saturating at 16'hFFFF.
    - If StreamValid & StreamSof at a position other than x = y = 0: Desync pulses the next cycle and the state goes to ST_ALIGN (pattern shown until realigned).
    - Pending with target = 0 takes effect at FrameEnd only, then the state goes to ST_PATTERN.
- Simultaneous events:
  - A SelRequest in the FrameEnd cycle is latched and applies at the next FrameEnd (ST_STREAM) or next cycle (ST_PATTERN).
  - Desync takes priority over a pending return to pattern.
- A reset mid-frame abandons the frame. The stream is not flushed by reset; ST_ALIGN handles realignment.

Decomposition:
- Shared package video_pkg holds:
  - state encodings ST_PATTERN = 2'd0, ST_ALIGN = 2'd1, ST_STREAM = 2'd2;
  - SRC_PATTERN and SRC_STREAM;
  - the colour constants used by the pattern generator and FILL_COLOR.
- One sub-module, video_position_counter: the x/y counters plus FrameStart and FrameEnd. It is reused by other video blocks.

Test Plan:
1. Reset held 3 cycles, then released. VideoReady continuous, no request. Check:
   - video == PatternVideo and PatternReady == VideoReady;
   - ActiveSrc = 0, StreamReady = 0;
   - after 480000 strobes, x = 0, y = 0 and FrameStart = 1.
2. Realignment and switch to stream. Setup: SelRequest (SelTarget = 1) at pixel 1000, with the stream presenting 5 non-SOF pixels and then a SOF. Check:
   - the 5 pixels are popped;
   - the SOF is held;
   - the switch occurs exactly at the FrameEnd cycle;
   - the first stream pixel is shown at x = y = 0.
3. Underflow. In ST_STREAM, drop StreamValid for 3 VideoReady cycles. Check:
   - FILL_COLOR is emitted 3 times;
   - 3 Underflow pulses;
   - UnderflowCount = 3;
   - x advances by 3.
4. Desync. Inject StreamSof at x = 17, y = 4. Check:
   - Desync pulses the next cycle;
   - the state goes to ST_ALIGN and video == PatternVideo;
   - realignment happens at the following FrameEnd.
5. Return to pattern. SelRequest (SelTarget = 0) mid-frame in ST_STREAM. Check:
   - the stream continues until FrameEnd;
   - ActiveSrc = 0 from x = y = 0.
   Then a request for 1 followed by a request for 0 one cycle later while in ST_PATTERN: check there is no state change and pending = 0.
6. Reset mid-operation. Assert Reset asynchronously mid-cycle in ST_STREAM with UnderflowCount = 5. Check that all outputs and counters immediately return to their reset values.
